// File: rtl/rc4_phase_sequencer.sv
// rc4_phase_sequencer: sequences init/shuffle/decrypt over the RC4 key space and steps the candidate key
module rc4_phase_sequencer #(
  parameter int KEY_WIDTH = 24,
  parameter logic [KEY_WIDTH-1:0] KEY_START = 24'h000000,
  parameter logic [KEY_WIDTH-1:0] KEY_LAST = 24'h3FFFFF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 init_done,
  input  logic                 shuffle_done,
  input  logic                 decrypt_done,
  input  logic                 decrypt_valid,
  output logic                 start_init,
  output logic                 start_shuffle,
  output logic                 start_decrypt,
  output logic [9:0]           ram_sel,
  output logic [KEY_WIDTH-1:0] key,
  output logic                 busy,
  output logic                 found,
  output logic                 failed
);
  typedef enum logic [3:0] {
    IDLE, INIT_GO, INIT_WAIT, SHUF_GO, SHUF_WAIT, DEC_GO, DEC_WAIT, CHECK, FOUND, FAIL
  } state_t;
  state_t state, state_n;
  logic valid;
  logic restart;
  assign restart = start && (state == IDLE || state == FOUND || state == FAIL);
  always_comb begin
    state_n = state;
    case (state)
      IDLE, FOUND, FAIL: state_n = start ? INIT_GO : state;
      INIT_GO:           state_n = INIT_WAIT;
      INIT_WAIT:         state_n = init_done ? SHUF_GO : INIT_WAIT;
      SHUF_GO:           state_n = SHUF_WAIT;
      SHUF_WAIT:         state_n = shuffle_done ? DEC_GO : SHUF_WAIT;
      DEC_GO:            state_n = DEC_WAIT;
      DEC_WAIT:          state_n = decrypt_done ? CHECK : DEC_WAIT;
      CHECK:             state_n = valid ? FOUND : (key == KEY_LAST) ? FAIL : INIT_GO;
      default:           state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      valid         <= 1'b0;
      key           <= KEY_START;
      ram_sel       <= 10'd0;
      start_init    <= 1'b0;
      start_shuffle <= 1'b0;
      start_decrypt <= 1'b0;
      busy          <= 1'b0;
      found         <= 1'b0;
      failed        <= 1'b0;
    end else begin
      state         <= state_n;
      valid         <= (state == DEC_WAIT && decrypt_done) ? decrypt_valid : valid;
      key           <= restart ? KEY_START : (state == CHECK && state_n == INIT_GO) ? key + KEY_WIDTH'(1) : key;
      ram_sel       <= (state_n == INIT_GO) ? 10'd0 : (state_n == SHUF_GO) ? 10'd1 : (state_n == DEC_GO) ? 10'd3 : ram_sel;
      start_init    <= state_n == INIT_GO;
      start_shuffle <= state_n == SHUF_GO;
      start_decrypt <= state_n == DEC_GO;
      busy          <= !(state_n inside {IDLE, FOUND, FAIL});
      found         <= state_n == FOUND;
      failed        <= state_n == FAIL;
    end
  end
endmodule

// File: tb/tb_rc4_phase_sequencer.sv
// tb_rc4_phase_sequencer: scoreboard bench for the RC4 phase sequencer
module tb_rc4_phase_sequencer;
  logic clk = 0, reset = 1, start = 0;
  logic eng_init = 0, eng_shuf = 0, eng_dec = 0, eng_valid = 0, spur_init = 0, spur_shuf = 0;
  logic init_done, shuffle_done, decrypt_done, decrypt_valid;
  logic start_init, start_shuffle, start_decrypt, busy, found, failed;
  logic [9:0] ram_sel;
  logic [23:0] key;
  logic start2 = 0, idone2 = 0, sdone2 = 0, ddone2 = 0, dvalid2 = 0;
  logic start_init2, start_shuffle2, start_decrypt2, busy2, found2, failed2;
  logic [9:0] ram_sel2;
  logic [23:0] key2;
  assign init_done = eng_init | spur_init;
  assign shuffle_done = eng_shuf | spur_shuf;
  assign decrypt_done = eng_dec;
  assign decrypt_valid = eng_valid;
  rc4_phase_sequencer dut (
    .clk(clk), .reset(reset), .start(start), .init_done(init_done), .shuffle_done(shuffle_done),
    .decrypt_done(decrypt_done), .decrypt_valid(decrypt_valid), .start_init(start_init),
    .start_shuffle(start_shuffle), .start_decrypt(start_decrypt), .ram_sel(ram_sel), .key(key),
    .busy(busy), .found(found), .failed(failed)
  );
  rc4_phase_sequencer #(.KEY_START(24'h3FFFFE), .KEY_LAST(24'h3FFFFF)) dut2 (
    .clk(clk), .reset(reset), .start(start2), .init_done(idone2), .shuffle_done(sdone2),
    .decrypt_done(ddone2), .decrypt_valid(dvalid2), .start_init(start_init2),
    .start_shuffle(start_shuffle2), .start_decrypt(start_decrypt2), .ram_sel(ram_sel2), .key(key2),
    .busy(busy2), .found(found2), .failed(failed2)
  );
  always #5 clk = ~clk;
  typedef struct packed {
    logic [2:0]  kind;
    logic [9:0]  sel;
    logic [23:0] key;
  } ev_t;
  ev_t exp_q[$];
  ev_t got, want;
  int n_tests = 0, n_fail = 0;
  logic [23:0] valid_key = '1;
  int ci = 0, cs = 0, cd = 0;
  initial forever begin
    @(negedge clk);
    eng_init = 0;
    eng_shuf = 0;
    eng_dec = 0;
    eng_valid = 0;
    if (reset) begin
      ci = 0;
      cs = 0;
      cd = 0;
    end else begin
      if (ci > 0) begin
        ci--;
        eng_init = (ci == 0);
      end
      if (cs > 0) begin
        cs--;
        eng_shuf = (cs == 0);
      end
      if (cd > 0) begin
        cd--;
        if (cd == 0) begin
          eng_dec = 1;
          eng_valid = (key == valid_key);
        end
      end
      if (start_init) ci = 256;
      if (start_shuffle) cs = 768;
      if (start_decrypt) cd = 20;
    end
  end
  always @(negedge clk) begin
    if (start_init | start_shuffle | start_decrypt) begin
      got = {start_init, start_shuffle, start_decrypt, ram_sel, key};
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL scoreboard_extra: got pulse=%b sel=%0d key=%h, required no pulse", got.kind, got.sel, got.key);
      end else begin
        want = exp_q.pop_front();
        if (got !== want) begin
          n_fail++;
          $display("FAIL scoreboard: got pulse=%b sel=%0d key=%h, required pulse=%b sel=%0d key=%h",
                   got.kind, got.sel, got.key, want.kind, want.sel, want.key);
        end
      end
    end
  end
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
  task automatic push_keys(input int a, input int b);
    for (int k = a; k <= b; k++) begin
      exp_q.push_back({3'b100, 10'd0, 24'(k)});
      exp_q.push_back({3'b010, 10'd1, 24'(k)});
      exp_q.push_back({3'b001, 10'd3, 24'(k)});
    end
  endtask
  task automatic pulse_start();
    @(negedge clk) start = 1;
    @(negedge clk) start = 0;
  endtask
  task automatic wait_found(input string nm);
    int n = 0;
    while (!found && n < 20000) begin
      @(negedge clk);
      n++;
    end
    n_tests++;
    if (found !== 1'b1) begin
      n_fail++;
      $display("FAIL %s_found: found=%b after %0d cycles, required 1", nm, found, n);
    end
  endtask
  function automatic logic sig2(input int w);
    return w == 0 ? start_init2 : w == 1 ? start_shuffle2 : w == 2 ? start_decrypt2 : failed2;
  endfunction
  task automatic wait2(input int w, input string nm);
    int n = 0;
    while (!sig2(w) && n < 40) begin
      @(negedge clk);
      n++;
    end
    n_tests++;
    if (sig2(w) !== 1'b1) begin
      n_fail++;
      $display("FAIL %s: got 0 after 40 cycles, required 1", nm);
    end
  endtask
  task automatic test_reset();
    reset = 1;
    repeat (3) @(negedge clk);
    n_tests++;
    if ({busy, found, failed, start_init, start_shuffle, start_decrypt} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_flags: got %b, required 000000",
               {busy, found, failed, start_init, start_shuffle, start_decrypt});
    end
    n_tests++;
    if (ram_sel !== 10'd0 || key !== 24'd0) begin
      n_fail++;
      $display("FAIL reset_sel_key: got sel=%0d key=%h, required sel=0 key=000000", ram_sel, key);
    end
    n_tests++;
    if (key2 !== 24'h3FFFFE) begin
      n_fail++;
      $display("FAIL reset_key2: got %h, required 3ffffe", key2);
    end
    reset = 0;
  endtask
  task automatic test_exhaust();
    logic [23:0] ek;
    @(negedge clk) start2 = 1;
    @(negedge clk) start2 = 0;
    for (int r = 0; r < 2; r++) begin
      wait2(0, "exh_init_pulse");
      ek = 24'h3FFFFE + 24'(r);
      n_tests++;
      if (key2 !== ek || ram_sel2 !== 10'd0 || busy2 !== 1'b1) begin
        n_fail++;
        $display("FAIL exh_round_key: got key=%h sel=%0d busy=%b, required key=%h sel=0 busy=1", key2, ram_sel2, busy2, ek);
      end
      @(negedge clk) idone2 = 1;
      @(negedge clk) idone2 = 0;
      wait2(1, "exh_shuf_pulse");
      @(negedge clk) sdone2 = 1;
      @(negedge clk) sdone2 = 0;
      wait2(2, "exh_dec_pulse");
      @(negedge clk) ddone2 = 1;
      @(negedge clk) ddone2 = 0;
    end
    wait2(3, "exh_failed");
    n_tests++;
    if (key2 !== 24'h3FFFFF || busy2 !== 1'b0 || found2 !== 1'b0) begin
      n_fail++;
      $display("FAIL exh_fail_state: got key=%h busy=%b found=%b, required key=3fffff busy=0 found=0", key2, busy2, found2);
    end
    repeat (4) @(negedge clk);
    n_tests++;
    if (start_init2 !== 1'b0 || key2 !== 24'h3FFFFF || failed2 !== 1'b1) begin
      n_fail++;
      $display("FAIL exh_no_wrap: got init=%b key=%h failed=%b, required init=0 key=3fffff failed=1", start_init2, key2, failed2);
    end
    @(negedge clk) start2 = 1;
    @(negedge clk) start2 = 0;
    n_tests++;
    if (key2 !== 24'h3FFFFE || failed2 !== 1'b0 || busy2 !== 1'b1 || start_init2 !== 1'b1) begin
      n_fail++;
      $display("FAIL exh_restart: got key=%h failed=%b busy=%b init=%b, required key=3ffffe failed=0 busy=1 init=1",
               key2, failed2, busy2, start_init2);
    end
  endtask
  task automatic test_single();
    valid_key = 24'd0;
    push_keys(0, 0);
    pulse_start();
    n_tests++;
    if ({start_init, ram_sel, key, busy} !== {1'b1, 10'd0, 24'd0, 1'b1}) begin
      n_fail++;
      $display("FAIL single_go: got init=%b sel=%0d key=%h busy=%b, required init=1 sel=0 key=000000 busy=1",
               start_init, ram_sel, key, busy);
    end
    @(negedge clk);
    n_tests++;
    if (start_init !== 1'b0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL single_pulse_width: got init=%b busy=%b, required init=0 busy=1", start_init, busy);
    end
    wait_found("single");
    n_tests++;
    if (key !== 24'd0 || busy !== 1'b0 || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL single_done: got key=%h busy=%b pending=%0d, required key=000000 busy=0 pending=0", key, busy, exp_q.size());
    end
  endtask
  task automatic test_multi();
    valid_key = 24'd5;
    push_keys(0, 5);
    pulse_start();
    n_tests++;
    if (found !== 1'b0 || busy !== 1'b1 || key !== 24'd0) begin
      n_fail++;
      $display("FAIL multi_restart: got found=%b busy=%b key=%h, required found=0 busy=1 key=000000", found, busy, key);
    end
    wait_found("multi");
    n_tests++;
    if (key !== 24'd5 || failed !== 1'b0 || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL multi_done: got key=%h failed=%b pending=%0d, required key=000005 failed=0 pending=0", key, failed, exp_q.size());
    end
  endtask
  task automatic test_spurious();
    int n = 0;
    valid_key = 24'd0;
    push_keys(0, 0);
    @(negedge clk) start = 1;
    @(negedge clk) begin
      start = 0;
      spur_init = 1;
    end
    @(negedge clk) begin
      spur_init = 0;
      spur_shuf = 1;
    end
    @(negedge clk) spur_shuf = 0;
    n_tests++;
    if (start_shuffle !== 1'b0 || ram_sel !== 10'd0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL spur_init_wait: got shuf=%b sel=%0d busy=%b, required shuf=0 sel=0 busy=1", start_shuffle, ram_sel, busy);
    end
    while (!start_shuffle && n < 400) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk) start = 1;
    @(negedge clk) start = 0;
    n_tests++;
    if (start_init !== 1'b0 || ram_sel !== 10'd1 || busy !== 1'b1 || key !== 24'd0) begin
      n_fail++;
      $display("FAIL spur_start_busy: got init=%b sel=%0d busy=%b key=%h, required init=0 sel=1 busy=1 key=000000",
               start_init, ram_sel, busy, key);
    end
    wait_found("spur");
    n_tests++;
    if (key !== 24'd0 || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL spur_done: got key=%h pending=%0d, required key=000000 pending=0", key, exp_q.size());
    end
  endtask
  task automatic test_reset_mid();
    int n = 0;
    valid_key = '1;
    push_keys(0, 3);
    pulse_start();
    while (!(start_decrypt && key == 24'd3) && n < 10000) begin
      @(negedge clk);
      n++;
    end
    n_tests++;
    if (start_decrypt !== 1'b1 || key !== 24'd3) begin
      n_fail++;
      $display("FAIL midrst_reach: got dec=%b key=%h, required dec=1 key=000003", start_decrypt, key);
    end
    @(negedge clk) begin
      reset = 1;
      start = 1;
    end
    @(negedge clk) begin
      reset = 0;
      start = 0;
    end
    n_tests++;
    if ({busy, found, failed, start_init, start_shuffle, start_decrypt} !== 6'b0 || key !== 24'd0 || ram_sel !== 10'd0) begin
      n_fail++;
      $display("FAIL midrst_idle: got flags=%b key=%h sel=%0d, required flags=000000 key=000000 sel=0",
               {busy, found, failed, start_init, start_shuffle, start_decrypt}, key, ram_sel);
    end
    repeat (30) @(negedge clk);
    n_tests++;
    if (busy !== 1'b0 || found !== 1'b0 || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL midrst_hold: got busy=%b found=%b pending=%0d, required busy=0 found=0 pending=0", busy, found, exp_q.size());
    end
    valid_key = 24'd0;
    push_keys(0, 0);
    pulse_start();
    n_tests++;
    if (start_init !== 1'b1 || key !== 24'd0) begin
      n_fail++;
      $display("FAIL midrst_restart: got init=%b key=%h, required init=1 key=000000", start_init, key);
    end
    wait_found("midrst");
    n_tests++;
    if (key !== 24'd0 || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL midrst_done: got key=%h pending=%0d, required key=000000 pending=0", key, exp_q.size());
    end
  endtask
  initial begin
    test_reset();
    test_exhaust();
    test_single();
    test_multi();
    test_spurious();
    test_reset_mid();
    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/rc4_phase_sequencer.md
Name: rc4_phase_sequencer

Overview:
- Top-level controller for the RC4 decoder. It sequences the three S-memory users in order: init (S[i]=i), shuffle (key schedule) and decrypt/check.
- It drives the select code for the shared S-RAM request mux, issues one-cycle start pulses and collects done strobes.
- It steps a key counter through the search space until decrypt reports valid plaintext or the space is exhausted.

Parameters:
- KEY_WIDTH, 24, width of the secret key bus.
- KEY_START, 24'h000000, first key tried after each start.
- KEY_LAST, 24'h3FFFFF, last key tried; search fails after this key.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- start  in  1  level/pulse; sampled only in IDLE, FOUND, FAIL
- init_done  in  1  one-cycle strobe from init engine
- shuffle_done  in  1  one-cycle strobe from shuffle engine
- decrypt_done  in  1  one-cycle strobe from decrypt engine
- decrypt_valid  in  1  qualifies decrypt_done: 1 = all plaintext bytes legal
- start_init  out  1  one-cycle start pulse to init engine
- start_shuffle  out  1  one-cycle start pulse to shuffle engine
- start_decrypt  out  1  one-cycle start pulse to decrypt engine
- ram_sel  out  10  S-RAM mux select: 0=init, 1=shuffle, 3=decrypt
- key  out  KEY_WIDTH  current candidate key to shuffle/decrypt
- busy  out  1  high from leaving IDLE until FOUND/FAIL
- found  out  1  high in FOUND
- failed  out  1  high in FAIL

Behaviour:
- Single clock domain. All state and outputs are registered. Reset is synchronous and active-high on clk.
- Reset values: state=IDLE, key=KEY_START, ram_sel=0, all start_* pulses=0, busy=0, found=0, failed=0.
- States: IDLE, INIT_GO, INIT_WAIT, SHUF_GO, SHUF_WAIT, DEC_GO, DEC_WAIT, CHECK, FOUND, FAIL.
- IDLE:
  - start=1 moves to INIT_GO next cycle, loads key=KEY_START and sets busy=1.
  - Otherwise the block holds.
- INIT_GO:
  - ram_sel=0 and start_init=1 for exactly this cycle.
  - Always moves to INIT_WAIT.
- INIT_WAIT: ram_sel=0. init_done=1 moves to SHUF_GO.
- SHUF_GO: ram_sel=1 and start_shuffle=1 for one cycle, then SHUF_WAIT.
- SHUF_WAIT: ram_sel=1. shuffle_done=1 moves to DEC_GO.
- DEC_GO: ram_sel=3 and start_decrypt=1 for one cycle, then DEC_WAIT.
- DEC_WAIT: ram_sel=3. decrypt_done=1 moves to CHECK and registers decrypt_valid.
- CHECK (one cycle, ram_sel=3):
  - Registered valid=1 moves to FOUND; key is held.
  - Valid=0 and key==KEY_LAST moves to FAIL; key is held, with no wrap-around.
  - Valid=0 and key!=KEY_LAST moves to INIT_GO with key=key+1. The S array is re-initialised for every key.
- FOUND: busy=0, found=1, key frozen at the successful key. start=1 restarts exactly as from IDLE and clears found.
- FAIL: busy=0, failed=1, key=KEY_LAST. start=1 restarts as from IDLE and clears failed.
- ram_sel changes only on entry to a *_GO state. It is stable for the whole GO+WAIT window, so the mux never switches while an engine owns the RAM.
- Done strobes are honoured only in their own WAIT state. A done strobe arriving in any other state, including the matching GO cycle, is ignored.
- start while busy=1 is ignored.
- Simultaneous done strobes in a WAIT state: only the matching one is acted on.
- decrypt_valid is ignored unless decrypt_done=1 in DEC_WAIT.
- Reset asserted mid-search: the next cycle is IDLE with all reset values. Any start pulse in the reset cycle is suppressed.
- key only increments in CHECK. Arithmetic is KEY_WIDTH-bit unsigned; the equality test against KEY_LAST prevents overflow.
- Latency for one key, from INIT_GO: 3 fixed GO cycles + 1 CHECK cycle + engine latencies + 3 WAIT-exit cycles.

Test Plan:
- Reset, then start=1 for one cycle -> next cycle INIT_GO: start_init=1, ram_sel=0, key=0x000000, busy=1. Following cycle start_init=0.
- Engines model init_done after 256 cycles, shuffle_done after 768 cycles, decrypt_done with valid=1 -> start pulses in order init, shuffle, decrypt, each exactly one cycle. ram_sel sequence is 0,1,3. found=1, busy=0, key=0.
- decrypt_valid=0 for keys 0..4 and 1 for key 5 -> six full init/shuffle/decrypt rounds; found=1 with key=0x000005; ram_sel returns to 0 at each new INIT_GO.
- KEY_START=24'h3FFFFE, KEY_LAST=24'h3FFFFF, valid always 0 -> two rounds then failed=1, key=0x3FFFFF, no wrap to 0. A further start restarts with key=0x3FFFFE and failed cleared.
- Spurious strobes: shuffle_done pulsed during INIT_WAIT, init_done pulsed during INIT_GO, start pulsed during SHUF_WAIT -> state, key and ram_sel unaffected; sequence completes normally.
- reset asserted during DEC_WAIT with key=0x000003 -> next cycle IDLE, key=0, ram_sel=0, busy=0, no start pulses; a subsequent start begins again at key 0.
